// File: rtl/product_serializer_pkg.sv
// Shared types and defaults for the product-word serializer.
// The FSM state enum lives here so the serializer and any future peers agree on it.
package product_serializer_pkg;

  localparam int DATA_W_DEFAULT = 16;
  localparam int DEPTH_DEFAULT  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/product_fifo.sv
// Word FIFO for the serializer; pointers carry one extra wrap bit so full and empty
// are distinguishable without a separate counter.
module product_fifo
  import product_serializer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level    = wr_ptr - rd_ptr;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/product_serializer.sv
// Serializes queued product words MSB first over a valid/ready bit stream,
// back-to-back with no idle cycle when another word is already queued.
module product_serializer
  import product_serializer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     ser_data,
  output logic                     ser_valid,
  output logic                     ser_last,
  input  logic                     ser_ready,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int CW = $clog2(DATA_W);

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              xfer;
  logic              last_bit;

  // in_ready is a pure function of registered FIFO state, so a same-cycle pop never frees a slot.
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign last_bit = (bit_cnt == CW'(DATA_W - 1));

  product_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_next = state;
    ser_valid  = 1'b0;
    ser_data   = 1'b0;
    ser_last   = 1'b0;
    xfer       = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        ser_valid = 1'b1;
        ser_data  = shreg[DATA_W-1];
        ser_last  = last_bit;
        xfer      = ser_ready;
        if (ser_ready && last_bit) begin
          if (!fifo_empty) pop = 1'b1;
          else             state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A pop always wins over a shift: it only coincides with the final bit leaving.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (pop) begin
      shreg   <= head;
      bit_cnt <= '0;
    end else if (xfer) begin
      shreg   <= {shreg[DATA_W-2:0], 1'b0};
      bit_cnt <= bit_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_product_serializer.sv
// Self-checking bench: a queue-based reference model checked every cycle, plus directed
// scenarios with hand-computed expectations for ordering, back-pressure and reset.
module tb_product_serializer;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              ser_data;
  logic              ser_valid;
  logic              ser_last;
  logic              ser_ready;
  logic [LW-1:0]     level;

  int checks = 0;
  int errors = 0;

  product_serializer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ser_data  (ser_data),
    .ser_valid (ser_valid),
    .ser_last  (ser_last),
    .ser_ready (ser_ready),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending words in a queue, plus the word on the wire and how many bits have left.
  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] m_cur = '0;
  int                m_sent = 0;
  bit                m_busy = 1'b0;
  bit                m_accept;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_busy = 1'b0;
      m_sent = 0;
      m_cur  = '0;
    end else begin
      m_accept = in_valid && (m_q.size() != DEPTH);
      if (m_busy && ser_ready) begin
        m_sent++;
        if (m_sent == DATA_W) m_busy = 1'b0;
      end
      if (!m_busy && m_q.size() > 0) begin
        m_cur  = m_q.pop_front();
        m_sent = 0;
        m_busy = 1'b1;
      end
      if (m_accept) m_q.push_back(in_data);
    end
  end

  logic exp_bit;
  always @(negedge clk) begin
    exp_bit = m_busy ? m_cur[DATA_W-1-m_sent] : 1'b0;
    check("ser_valid", ser_valid, m_busy);
    check("ser_data", ser_data, exp_bit);
    check("ser_last", ser_last, m_busy && (m_sent == DATA_W - 1));
    check("level", level, m_q.size());
    check("in_ready", in_ready, m_q.size() != DEPTH);
  end

  // Receiver: rebuilds words and records where ser_last fell inside each valid run.
  logic [DATA_W-1:0] rx_word = '0;
  logic [DATA_W-1:0] rx_q[$];
  int                run = 0;
  int                runs[$];
  int                last_at[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_word = '0;
      run     = 0;
    end else if (ser_valid) begin
      run++;
      if (ser_ready) begin
        rx_word = {rx_word[DATA_W-2:0], ser_data};
        if (ser_last) begin
          rx_q.push_back(rx_word);
          last_at.push_back(run);
        end
      end
    end else if (run > 0) begin
      runs.push_back(run);
      run = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rx();
    rx_q.delete();
    runs.delete();
    last_at.delete();
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w);
    logic rdy;
    int   n;
    n        = 0;
    in_data  = w;
    in_valid = 1'b1;
    do begin
      rdy = in_ready;
      tick();
      n++;
    end while (!rdy && n < 50);
    in_valid = 1'b0;
    check("push_accepted", rdy, 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((ser_valid || level != 0) && n < budget) begin
      tick();
      n++;
    end
    check("idle_within_budget", n < budget, 1'b1);
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_level"}, level, 0);
    check({tag, "_ser_valid"}, ser_valid, 1'b0);
    check({tag, "_ser_last"}, ser_last, 1'b0);
    check({tag, "_ser_data"}, ser_data, 1'b0);
  endtask

  initial begin
    logic [DATA_W-1:0] words [6];
    int                n;
    words = '{16'h1001, 16'h2002, 16'h3003, 16'h4004, 16'h5005, 16'h6006};

    rst_n     = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    ser_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Single word 0xA5C3, no push-to-shift bypass.
    ser_ready = 1'b1;
    clear_rx();
    push_word(16'hA5C3);
    check("no_bypass_valid", ser_valid, 1'b0);
    check("no_bypass_level", level, 1);
    tick();
    check("first_shift_valid", ser_valid, 1'b1);
    check("first_bit", ser_data, 1'b1);
    wait_idle(100);
    check("a5c3_words", rx_q.size(), 1);
    check("a5c3_word", rx_q.size() > 0 ? rx_q[0] : 16'h0, 16'hA5C3);
    check("a5c3_run", runs.size() > 0 ? runs[0] : 0, 16);
    check("a5c3_last_pos", last_at.size() > 0 ? last_at[0] : 0, 16);

    // Three words back to back: one unbroken 48-bit run.
    clear_rx();
    push_word(16'h0001);
    push_word(16'h8000);
    push_word(16'hFFFF);
    wait_idle(200);
    check("b2b_words", rx_q.size(), 3);
    check("b2b_w0", rx_q.size() > 0 ? rx_q[0] : 16'h0, 16'h0001);
    check("b2b_w1", rx_q.size() > 1 ? rx_q[1] : 16'h0, 16'h8000);
    check("b2b_w2", rx_q.size() > 2 ? rx_q[2] : 16'h0, 16'hFFFF);
    check("b2b_runs", runs.size(), 1);
    check("b2b_run_len", runs.size() > 0 ? runs[0] : 0, 48);
    check("b2b_last0", last_at.size() > 0 ? last_at[0] : 0, 16);
    check("b2b_last1", last_at.size() > 1 ? last_at[1] : 0, 32);
    check("b2b_last2", last_at.size() > 2 ? last_at[2] : 0, 48);

    // Back-pressure: five words fill shifter + FIFO, the sixth is held off.
    clear_rx();
    ser_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(words[i]);
    check("full_level", level, 4);
    check("full_in_ready", in_ready, 1'b0);
    check("full_shifting", ser_valid, 1'b1);
    in_data  = words[5];
    in_valid = 1'b1;
    repeat (3) tick();
    check("held_off_level", level, 4);
    ser_ready = 1'b1;
    repeat (15) tick();
    check("at_last_bit", ser_last, 1'b1);
    check("at_last_level", level, 4);
    tick();
    check("pop_refuses_push_level", level, 3);
    check("pop_refuses_push_ready", in_ready, 1'b1);
    tick();
    check("push_next_edge_level", level, 4);
    in_valid = 1'b0;
    wait_idle(300);
    check("bp_words", rx_q.size(), 6);
    for (int i = 0; i < 6; i++)
      check("bp_word", rx_q.size() > i ? rx_q[i] : 16'h0, words[i]);

    // Stalls every other cycle.
    clear_rx();
    ser_ready = 1'b0;
    push_word(16'h1234);
    n = 0;
    while ((ser_valid || level != 0) && n < 100) begin
      ser_ready = ~ser_ready;
      tick();
      n++;
    end
    check("toggle_done", n < 100, 1'b1);
    tick();
    check("toggle_words", rx_q.size(), 1);
    check("toggle_word", rx_q.size() > 0 ? rx_q[0] : 16'h0, 16'h1234);

    // Reset mid-word with two words queued.
    ser_ready = 1'b0;
    push_word(16'hBEEF);
    push_word(16'h1111);
    push_word(16'h2222);
    check("pre_reset_level", level, 2);
    ser_ready = 1'b1;
    repeat (7) tick();
    ser_ready = 1'b0;
    check("pre_reset_valid", ser_valid, 1'b1);
    rst_n = 1'b0;
    #1 check_reset_outputs("midword_reset");
    repeat (2) tick();
    rst_n     = 1'b1;
    ser_ready = 1'b1;
    clear_rx();
    tick();
    check("post_reset_idle", ser_valid, 1'b0);
    push_word(16'h00FF);
    wait_idle(100);
    check("post_reset_words", rx_q.size(), 1);
    check("post_reset_word", rx_q.size() > 0 ? rx_q[0] : 16'h0, 16'h00FF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
